// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: buffers bytes in a small FIFO and shifts one start/data/stop frame per
// byte onto txd, stepping one bit per bps_clk strobe while holding the baud generator enabled.
module uart_tx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 bps_clk,
  output logic                 count_sig,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned IdxW  = $clog2(DATA_BITS + 4);

  localparam logic [IdxW-1:0]    IdxOne      = IdxW'(1);
  localparam logic [IdxW-1:0]    IdxLastData = IdxW'(DATA_BITS + 1);
  localparam logic [IdxW-1:0]    IdxStop     = IdxW'(DATA_BITS + 2);
  localparam logic [FIFO_AW-1:0] PtrOne      = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LvlOne      = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   LvlFull     = (FIFO_AW + 1)'(Depth);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [Depth];
  logic [FIFO_AW-1:0]     wptr_q, wptr_d;
  logic [FIFO_AW-1:0]     rptr_q, rptr_d;
  logic [FIFO_AW:0]       level_q, level_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
  logic [IdxW-1:0]        idx_nxt;
  logic                   count_sig_q, count_sig_d;
  logic                   txd_q, txd_d;
  logic                   tx_done_q, tx_done_d;
  logic                   push, pop, full;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push while IDLE drains it.
  always_comb begin
    full     = (level_q == LvlFull);
    pop      = (state_q == StIdle) && !count_sig_q && (level_q != '0);
    tx_ready = !full || pop;
    push     = tx_valid && tx_ready;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + PtrOne;
    if (pop)  rptr_d = rptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    count_sig_d = count_sig_q;
    txd_d       = txd_q;
    tx_done_d   = 1'b0;
    idx_nxt     = bit_idx_q + IdxOne;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d     = mem_q[rptr_q];
          bit_idx_d   = '0;
          count_sig_d = 1'b1;
          txd_d       = 1'b1;
          state_d     = StActive;
        end
      end
      StActive: begin
        if (bps_clk) begin
          bit_idx_d = idx_nxt;
          if (idx_nxt == IdxOne) begin
            txd_d = 1'b0;
          end else if (idx_nxt <= IdxLastData) begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (idx_nxt == IdxStop) begin
            txd_d = 1'b1;
          end else begin
            // Stop bit has now been held a full period; release the baud counter.
            txd_d       = 1'b1;
            count_sig_d = 1'b0;
            tx_done_d   = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      count_sig_q <= 1'b0;
      txd_q       <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      count_sig_q <= count_sig_d;
      txd_q       <= txd_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign count_sig  = count_sig_q;
  assign txd        = txd_q;
  assign busy       = (state_q == StActive);
  assign tx_done    = tx_done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected 10-bit frames, a monitor decodes
// txd at every bit strobe and checks each frame when tx_done fires.
module tb_uart_tx_ctrl;

  localparam int Period = 8;
  localparam int Half   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       bps_force = 1'b0;
  logic       tx_ready, bps_clk, bps_gen, count_sig, txd, busy, tx_done;
  logic [2:0] fifo_level;

  uart_tx_ctrl #(.DATA_BITS(8), .FIFO_AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .bps_clk    (bps_clk),
    .count_sig  (count_sig),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Miniature baud generator: counts only while enabled, strobes mid-period.
  int cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= 0;
    else if (!count_sig) cnt <= 0;
    else                 cnt <= (cnt == Period - 1) ? 0 : cnt + 1;
  end
  assign bps_gen = count_sig && (cnt == Half - 1);
  assign bps_clk = bps_gen | bps_force;

  int checks = 0;
  int passes = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Monitor: bit captured on the negedge after the strobe's edge; checked against queue on tx_done.
  int         npulse = 0;
  bit         pend = 1'b0;
  logic [10:0] bits = '0;
  logic [9:0] exp_frame;
  always @(negedge clk) begin
    if (!rst_n) begin
      npulse = 0;
      pend   = 1'b0;
    end else begin
      if (pend && npulse <= 11) begin
        bits[npulse-1] = txd;
        if (npulse == 11) chk("tx_done_after_pulse11", tx_done, 1);
      end
      if (busy && npulse == 0) chk("txd_high_before_start", txd, 1);
      if (tx_done) begin
        chk("count_sig_low_with_done", count_sig, 0);
        chk("pulses_per_frame", npulse, 11);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_frame = exp_q.pop_front();
          chk("frame_bits", bits[9:0], exp_frame);
        end
        npulse = 0;
      end
      pend = bps_clk && busy;
      if (pend) npulse++;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(!busy && !count_sig && fifo_level == 0 && exp_q.size() == 0 && !tx_done)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (!busy && !count_sig && fifo_level == 0 && exp_q.size() == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   accepted;
    logic ready_hist [8];
    int   n;
    bit   any_start;

    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_count_sig", count_sig, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_done", tx_done, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5: pulses 1..10 = 0,1,0,1,0,0,1,0,1,1.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    exp_q.push_back(10'h34A);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle("idle_after_a5");

    // tx_valid held 8 cycles: one popped immediately, four more fill the FIFO.
    for (int i = 1; i <= 5; i++) exp_q.push_back(frame(8'(i)));
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      tx_valid      = 1'b1;
      tx_data       = 8'(i + 1);
      ready_hist[i] = tx_ready;
      if (tx_ready) accepted++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("burst_accepted", accepted, 5);
    chk("burst_ready_after_5th", ready_hist[5], 0);
    chk("burst_ready_now", tx_ready, 0);
    chk("burst_level", fifo_level, 4);
    wait_idle("idle_after_burst");

    // Strobes while idle are ignored.
    bps_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_bps_txd", txd, 1);
      chk("idle_bps_count_sig", count_sig, 0);
      chk("idle_bps_tx_done", tx_done, 0);
    end
    bps_force = 1'b0;
    @(negedge clk);
    chk("idle_bps_busy", busy, 0);

    // Full FIFO, push offered in the pop cycle right after tx_done.
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'h11 * 8'(i + 1);
      exp_q.push_back(frame(8'h11 * 8'(i + 1)));
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("full_level", fifo_level, 4);
    chk("full_ready", tx_ready, 0);
    n = 0;
    while (!tx_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("full_saw_tx_done", tx_done, 1);
    chk("pop_cycle_ready", tx_ready, 1);
    chk("pop_cycle_level", fifo_level, 4);
    tx_valid = 1'b1;
    tx_data  = 8'h66;
    exp_q.push_back(frame(8'h66));
    @(negedge clk);
    tx_valid = 1'b0;
    chk("pop_push_level", fifo_level, 4);
    chk("pop_push_count_sig", count_sig, 1);
    wait_idle("idle_after_full");

    // Reset after pulse 5 with two bytes queued; 0x77 bit3 puts txd low at that point.
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'h77 + 8'(i * 17);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    n = 0;
    accepted = 0;
    while (accepted < 5 && n < 300) begin
      if (bps_clk && busy) accepted++;
      if (accepted < 5) @(negedge clk);
      n++;
    end
    chk("reset_frame_reached_pulse5", accepted, 5);
    @(posedge clk);
    #2;
    chk("txd_before_reset", txd, 0);
    chk("level_before_reset", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    chk("midreset_txd", txd, 1);
    chk("midreset_count_sig", count_sig, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_tx_done", tx_done, 0);
    chk("midreset_tx_ready", tx_ready, 1);
    chk("midreset_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_start |= count_sig | busy | tx_done;
    end
    chk("no_frame_after_reset", any_start, 0);
    chk("level_after_reset", fifo_level, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
